draw_span: RTL

Rasterises one vertical pixel span handed over by the line-stepping stage into the current frameblock. It latches a 249-bit span descriptor on `span_start` and walks from `y_start` to `y_end` one pixel per cycle, stepping z/r/g/b/u/v. It depth-tests each pixel against the frameblock z-buffer and writes colour and z for visible pixels. It reports idle on `span_done`, which the line stage polls before issuing the next span.

---
 rtl/mch3d_pkg.sv | 67 ++++++
 rtl/draw_span_attr_step.sv | 28 ++
 rtl/draw_span.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mch3d_pkg.sv
// mch3d_pkg: shared definitions for the span rasteriser and the line stage.
//   - 249-bit span descriptor field widths and LSB offsets
//   - frameblock address / z widths
//   - per-span attribute and step bundles, span FSM states
//   - RGB565 packing helper
package mch3d_pkg;

  localparam int FB_ADDR_W = 10;
  localparam int Z_W       = 15;
  localparam int FRAC_W    = 9;
  localparam int SPAN_W    = 249;

  localparam int Y_W    = 8;
  localparam int X_W    = 3;
  localparam int SP_Z_W = 24;
  localparam int SP_R_W = 14;
  localparam int SP_G_W = 15;
  localparam int SP_B_W = 14;
  localparam int SP_U_W = 21;
  localparam int SP_V_W = 21;

  // Each step field is one bit wider than its attribute. Every attribute
  // is preceded (MSB side) by a single zero pad bit.
  localparam int SP_NV_LSB = 0;
  localparam int SP_V_LSB  = SP_NV_LSB + SP_V_W + 1;
  localparam int SP_NU_LSB = SP_V_LSB + SP_V_W + 1;
  localparam int SP_U_LSB  = SP_NU_LSB + SP_U_W + 1;
  localparam int SP_NB_LSB = SP_U_LSB + SP_U_W + 1;
  localparam int SP_B_LSB  = SP_NB_LSB + SP_B_W + 1;
  localparam int SP_NG_LSB = SP_B_LSB + SP_B_W + 1;
  localparam int SP_G_LSB  = SP_NG_LSB + SP_G_W + 1;
  localparam int SP_NR_LSB = SP_G_LSB + SP_G_W + 1;
  localparam int SP_R_LSB  = SP_NR_LSB + SP_R_W + 1;
  localparam int SP_NZ_LSB = SP_R_LSB + SP_R_W + 1;
  localparam int SP_Z_LSB  = SP_NZ_LSB + SP_Z_W + 1;
  localparam int SP_X_LSB  = SP_Z_LSB + SP_Z_W + 1;
  localparam int SP_YE_LSB = SP_X_LSB + X_W;
  localparam int SP_YS_LSB = SP_YE_LSB + Y_W;

  typedef struct packed {
    logic [SP_Z_W-1:0] z;
    logic [SP_R_W-1:0] r;
    logic [SP_G_W-1:0] g;
    logic [SP_B_W-1:0] b;
    logic [SP_U_W-1:0] u;
    logic [SP_V_W-1:0] v;
  } attr_t;

  typedef struct packed {
    logic [SP_Z_W:0] z;
    logic [SP_R_W:0] r;
    logic [SP_G_W:0] g;
    logic [SP_B_W:0] b;
    logic [SP_U_W:0] u;
    logic [SP_V_W:0] v;
  } step_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} span_state_e;

  // Integer parts of the colour attributes, truncated to 5/6/5 bits.
  function automatic logic [15:0] rgb565(input logic [SP_R_W-1:0] r,
                                         input logic [SP_G_W-1:0] g,
                                         input logic [SP_B_W-1:0] b);
    return {r[SP_R_W-1 -: 5], g[SP_G_W-1 -: 6], b[SP_B_W-1 -: 5]};
  endfunction

endpackage

// File: rtl/draw_span_attr_step.sv
// attr_step: one saturating interpolation step of an unsigned attribute.
//   val_i  : current attribute (unsigned, W bits)
//   step_i : signed per-pixel increment (W+1 bits)
//   up_i   : 1 = add step, 0 = subtract step
//   val_o  : stepped value clamped to [0, 2^W-1]
module attr_step
  import mch3d_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0] val_i,
  input  logic [W:0]   step_i,
  input  logic         up_i,
  output logic [W-1:0] val_o
);

  // Two extra bits hold the full range of unsigned +/- signed operands.
  logic signed [W+1:0] sum;

  always_comb begin
    if (up_i) sum = $signed({2'b00, val_i}) + $signed({step_i[W], step_i});
    else      sum = $signed({2'b00, val_i}) - $signed({step_i[W], step_i});
    if (sum[W+1])  val_o = '0;          // went negative
    else if (sum[W]) val_o = '1;        // overflowed the attribute range
    else           val_o = sum[W-1:0];
  end

endmodule

// File: rtl/draw_span.sv
// draw_span: rasterises one vertical span into the frameblock.
//   clk, rst          : clock, synchronous active-high reset
//   span_data/start   : descriptor, latched on the start pulse while idle
//   span_done         : high while idle and ready for the next span
//   zbuf_rd/rdaddr    : z read, data returns on zbuf_rddata the next cycle
//   zbuf_wr/wraddr/wrdata : z write for visible pixels
//   pix_wr/wraddr/rgb/uv  : colour write, mirrors the z write
// Pipeline: stage 1 (RUN) reads z and steps attributes; stage 2 compares the
// returned z and writes. DRAIN gives the last pixel its stage-2 cycle.
module draw_span
  import mch3d_pkg::*;
#(
  parameter int Z_TEST_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SPAN_W-1:0]    span_data,
  input  logic                 span_start,
  output logic                 span_done,
  output logic [FB_ADDR_W-1:0] zbuf_rdaddr,
  output logic                 zbuf_rd,
  input  logic [Z_W-1:0]       zbuf_rddata,
  output logic [FB_ADDR_W-1:0] zbuf_wraddr,
  output logic                 zbuf_wr,
  output logic [Z_W-1:0]       zbuf_wrdata,
  output logic [FB_ADDR_W-1:0] pix_wraddr,
  output logic                 pix_wr,
  output logic [15:0]          pix_rgb,
  output logic [23:0]          pix_uv
);

  localparam int UV_W = SP_U_W - FRAC_W;

  span_state_e state_q, state_d;

  logic [Y_W-1:0]       y_q, y_d, ye_q, ye_d;
  logic [1:0]           x_q, x_d;
  logic                 up_q, up_d;
  attr_t                at_q, at_d, at_nx, at_in;
  step_t                st_q, st_d, st_in;

  logic                 done_q, done_d;
  logic                 rd_q, rd_d;
  logic [FB_ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [FB_ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [Z_W-1:0]       s2_z_q, s2_z_d;
  logic [15:0]          s2_rgb_q, s2_rgb_d;
  logic [23:0]          s2_uv_q, s2_uv_d;

  logic [Y_W-1:0]       in_ys, in_ye;
  logic [X_W-1:0]       in_x;
  logic                 z_pass;

  // ---------------------------------------------------------------- unpack
  assign in_ys = span_data[SP_YS_LSB +: Y_W];
  assign in_ye = span_data[SP_YE_LSB +: Y_W];
  assign in_x  = span_data[SP_X_LSB +: X_W];
  assign at_in = {span_data[SP_Z_LSB +: SP_Z_W], span_data[SP_R_LSB +: SP_R_W],
                  span_data[SP_G_LSB +: SP_G_W], span_data[SP_B_LSB +: SP_B_W],
                  span_data[SP_U_LSB +: SP_U_W], span_data[SP_V_LSB +: SP_V_W]};
  assign st_in = {span_data[SP_NZ_LSB +: SP_Z_W+1], span_data[SP_NR_LSB +: SP_R_W+1],
                  span_data[SP_NG_LSB +: SP_G_W+1], span_data[SP_NB_LSB +: SP_B_W+1],
                  span_data[SP_NU_LSB +: SP_U_W+1], span_data[SP_NV_LSB +: SP_V_W+1]};

  // x[2] selects a frameblock half handled elsewhere; pad bits are always 0.
  logic unused_bits;
  assign unused_bits = ^{in_x[2],
                         span_data[SP_Z_LSB + SP_Z_W], span_data[SP_R_LSB + SP_R_W],
                         span_data[SP_G_LSB + SP_G_W], span_data[SP_B_LSB + SP_B_W],
                         span_data[SP_U_LSB + SP_U_W], span_data[SP_V_LSB + SP_V_W]};

  // ------------------------------------------------------- attribute steps
  logic [SP_Z_W-1:0] z_nx;
  logic [SP_R_W-1:0] r_nx;
  logic [SP_G_W-1:0] g_nx;
  logic [SP_B_W-1:0] b_nx;
  logic [SP_U_W-1:0] u_nx;
  logic [SP_V_W-1:0] v_nx;

  attr_step #(.W(SP_Z_W)) u_step_z (.val_i(at_q.z), .step_i(st_q.z), .up_i(up_q), .val_o(z_nx));
  attr_step #(.W(SP_R_W)) u_step_r (.val_i(at_q.r), .step_i(st_q.r), .up_i(up_q), .val_o(r_nx));
  attr_step #(.W(SP_G_W)) u_step_g (.val_i(at_q.g), .step_i(st_q.g), .up_i(up_q), .val_o(g_nx));
  attr_step #(.W(SP_B_W)) u_step_b (.val_i(at_q.b), .step_i(st_q.b), .up_i(up_q), .val_o(b_nx));
  attr_step #(.W(SP_U_W)) u_step_u (.val_i(at_q.u), .step_i(st_q.u), .up_i(up_q), .val_o(u_nx));
  attr_step #(.W(SP_V_W)) u_step_v (.val_i(at_q.v), .step_i(st_q.v), .up_i(up_q), .val_o(v_nx));

  assign at_nx = {z_nx, r_nx, g_nx, b_nx, u_nx, v_nx};

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (span_start) state_d = ST_RUN;
      ST_RUN:   if (y_q == ye_q) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output-side next values; every port is driven from a flop below, except
  // the write strobe which qualifies the registered stage-2 valid with the
  // depth compare on the returning read data.
  always_comb begin
    done_d    = (state_d == ST_IDLE);
    rd_d      = (state_d == ST_RUN);
    rdaddr_d  = {x_d, y_d};
    s2_vld_d  = (state_q == ST_RUN);
    s2_addr_d = {x_q, y_q};
    s2_z_d    = at_q.z[SP_Z_W-1 -: Z_W];
    s2_rgb_d  = rgb565(at_q.r, at_q.g, at_q.b);
    s2_uv_d   = {at_q.u[SP_U_W-1 -: UV_W], at_q.v[SP_V_W-1 -: UV_W]};
  end

  // --------------------------------------------------------- span datapath
  always_comb begin
    y_d  = y_q;
    ye_d = ye_q;
    x_d  = x_q;
    up_d = up_q;
    at_d = at_q;
    st_d = st_q;
    if (state_q == ST_IDLE && span_start) begin
      y_d  = in_ys;
      ye_d = in_ye;
      x_d  = in_x[1:0];
      up_d = (in_ye >= in_ys);
      at_d = at_in;
      st_d = st_in;
    end else if (state_q == ST_RUN && y_q != ye_q) begin
      y_d  = up_q ? y_q + Y_W'(1) : y_q - Y_W'(1);
      at_d = at_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      ye_q      <= '0;
      x_q       <= '0;
      up_q      <= 1'b0;
      at_q      <= '0;
      st_q      <= '0;
      done_q    <= 1'b1;
      rd_q      <= 1'b0;
      rdaddr_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_z_q    <= '0;
      s2_rgb_q  <= '0;
      s2_uv_q   <= '0;
    end else begin
      y_q       <= y_d;
      ye_q      <= ye_d;
      x_q       <= x_d;
      up_q      <= up_d;
      at_q      <= at_d;
      st_q      <= st_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      rdaddr_q  <= rdaddr_d;
      s2_vld_q  <= s2_vld_d;
      s2_addr_q <= s2_addr_d;
      s2_z_q    <= s2_z_d;
      s2_rgb_q  <= s2_rgb_d;
      s2_uv_q   <= s2_uv_d;
    end
  end

  // Ties are rejected so coplanar surfaces keep the first-drawn pixel.
  assign z_pass = (Z_TEST_EN == 0) || (s2_z_q < zbuf_rddata);

  assign span_done   = done_q;
  assign zbuf_rd     = rd_q;
  assign zbuf_rdaddr = rdaddr_q;
  assign zbuf_wr     = s2_vld_q && z_pass;
  assign zbuf_wraddr = s2_addr_q;
  assign zbuf_wrdata = s2_z_q;
  assign pix_wr      = zbuf_wr;
  assign pix_wraddr  = s2_addr_q;
  assign pix_rgb     = s2_rgb_q;
  assign pix_uv      = s2_uv_q;

endmodule
